ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-port arbiter and sequencer in front of the single-port RAM. It accepts read/write requests from two independent requesters (A and B) and grants them round-robin. It drives the RAM's cs/wr/oe/addr pins and owns the bidirectional data bus whenever it writes. Read data is captured from the bus and returned to the requester that issued the read.

## Interface

Parameters:

- ADDR_WIDTH, 4, RAM address width
- DATA_WIDTH, 16, RAM data width

Ports:

- clk  in  1  single clock; all registers on posedge
- rst  in  1  asynchronous, active-high reset
- a_req  in  1  requester A request; held high until a_ack
- a_we  in  1  1 = write, 0 = read; stable while a_req
- a_addr  in  ADDR_WIDTH  access address; stable while a_req
- a_wdata  in  DATA_WIDTH  write data; stable while a_req
- a_ack  out  1  one-cycle pulse: A's access is being performed this cycle
- a_rdata  out  DATA_WIDTH  read data capture register (shared with b_rdata)
- a_rvalid  out  1  one-cycle pulse: a_rdata holds A's read result
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata, b_rvalid: identical to A
- ram_cs  out  1  RAM chip select
- ram_wr  out  1  RAM write enable
- ram_oe  out  1  RAM output enable
- ram_addr  out  ADDR_WIDTH  RAM address
- ram_data  inout  DATA_WIDTH  RAM data bus; driven only in WR state, else high-Z

## Operation

- FSM has three states: IDLE, WR, RD. Every access takes exactly 2 cycles: IDLE, then WR or RD.
- IDLE: outputs ram_cs=0, ram_wr=0, ram_oe=0. The bus is released, and this cycle also serves as read-to-write bus turnaround.
  - At the posedge, if any req is high, choose the winner, latch its addr/wdata/we and owner id, and go to WR (we=1) or RD (we=0).
  - If no req is high, stay in IDLE.
- Arbitration:
  - Only one requester high: that requester wins.
  - Both high: the requester not granted last wins.
  - last_grant updates on every grant. It resets to B, so A wins the first tie.
- WR: ram_cs=1, ram_wr=1, ram_oe=0, ram_addr=latched addr, ram_data=latched wdata. The owner's ack is high. The RAM writes at the posedge ending WR. Next state is IDLE.
- RD: ram_cs=1, ram_wr=0, ram_oe=1, ram_addr=latched addr. The owner's ack is high.
  - The RAM updates its output at mid-cycle negedge.
  - At the posedge ending RD, ram_data is captured into the rdata register, and the owner's rvalid is set for the next cycle. Next state is IDLE.
- ram_cs/wr/oe/addr are registered, so they are glitch-free. The ram_data driver enable is decoded from the registered state == WR.
- Requesters drop or change req on the edge where they see ack. The controller ignores req outside IDLE.
- rdata holds its value until the next read capture, from either requester.
- A requester that drops req before ack withdraws its request; no access is performed.

## Timing

- Reset (async, immediate) gives: state=IDLE, ram_cs=0, ram_wr=0, ram_oe=0, ram_addr=0, ram_data=Z, a_ack=b_ack=0, a_rvalid=b_rvalid=0, rdata=0, last_grant=B.
- Reset asserted mid-WR or mid-RD aborts the access:
  - no ack continues and no rvalid is issued;
  - bus goes high-Z immediately;
  - a partially-timed write must not be assumed committed.
- Request sampled high at posedge T (in IDLE): ack and RAM access occur in cycle T..T+1. For a read, rvalid and rdata are valid in cycle T+1..T+2.
- Sustained throughput is one access per 2 cycles. Under contention from both requesters, A and B strictly alternate.
- ack and rvalid are single-cycle pulses, never high for both requesters in the same cycle.

## Test plan

- Reset then single write: A writes addr 3 = 16'hBEEF. Required:
  - a_ack is high for exactly one cycle;
  - during that cycle ram_cs=1, ram_wr=1, ram_addr=3, ram_data=BEEF;
  - the bus is Z in every other cycle.
- Read-back: B reads addr 3 after the previous write. Required:
  - b_ack is high in the RD cycle with ram_oe=1, ram_wr=0;
  - the next cycle has b_rvalid=1 and b_rdata=16'hBEEF;
  - a_rvalid stays 0.
- Simultaneous requests from idle after reset: A writes addr 1 = 16'h1111, B writes addr 2 = 16'h2222, both held. Required:
  - A is granted first, then B is granted 2 cycles later;
  - reading back returns 1111 and 2222.
- Continuous contention: both hold reads for 8 accesses. Required:
  - acks alternate A, B, A, B… every 2 cycles;
  - ram_cs is low in every intervening IDLE cycle.
- Read immediately followed by write: A reads addr 5, then B writes addr 5 = 16'h0F0F. Required:
  - an IDLE cycle (ram_cs=0, bus Z) separates the two accesses, so the bus never has two drivers;
  - a later read of addr 5 returns 0F0F.
- Reset mid-access: assert rst during the RD cycle. Required:
  - all outputs immediately take their reset values and no rvalid is issued;
  - after release, A wins the next tie.

Source files
------------

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ram_arbiter
//  Purpose  : Two-requester round-robin arbiter and access sequencer for a
//             single-port RAM with a shared bidirectional data bus.
//  Revision : 1.0  initial release
// ============================================================================
module ram_arbiter #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_ack,
    output logic [DATA_WIDTH-1:0] a_rdata,
    output logic                  a_rvalid,

    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_ack,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  b_rvalid,

    output logic                  ram_cs,
    output logic                  ram_wr,
    output logic                  ram_oe,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    inout  wire  [DATA_WIDTH-1:0] ram_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2
    } state_t;

    localparam logic c_own_a = 1'b0;
    localparam logic c_own_b = 1'b1;

    state_t                state_q,    state_d;
    logic                  owner_q,    owner_d;
    logic                  last_q,     last_d;
    logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,    wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q,    rdata_d;
    logic                  cs_q,       cs_d;
    logic                  wr_q,       wr_d;
    logic                  oe_q,       oe_d;
    logic                  a_ack_q,    a_ack_d;
    logic                  b_ack_q,    b_ack_d;
    logic                  a_rvalid_q, a_rvalid_d;
    logic                  b_rvalid_q, b_rvalid_d;

    logic                  w_pick_b;

    // B wins when it is alone, or on a tie when A was granted last.
    assign w_pick_b = b_req && (!a_req || (last_q == c_own_a));

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        a_ack_d    = 1'b0;
        b_ack_d    = 1'b0;
        a_rvalid_d = 1'b0;
        b_rvalid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (a_req || b_req) begin
                    owner_d = w_pick_b ? c_own_b : c_own_a;
                    last_d  = w_pick_b ? c_own_b : c_own_a;
                    addr_d  = w_pick_b ? b_addr  : a_addr;
                    wdata_d = w_pick_b ? b_wdata : a_wdata;
                    a_ack_d = !w_pick_b;
                    b_ack_d = w_pick_b;
                    if (w_pick_b ? b_we : a_we) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_WR: begin
                state_d = S_IDLE;
            end
            S_RD: begin
                // RAM output settled at the mid-cycle negedge.
                rdata_d    = ram_data;
                a_rvalid_d = (owner_q == c_own_a);
                b_rvalid_d = (owner_q == c_own_b);
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        cs_d = (state_d != S_IDLE);
        wr_d = (state_d == S_WR);
        oe_d = (state_d == S_RD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            owner_q    <= c_own_a;
            last_q     <= c_own_b;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            cs_q       <= 1'b0;
            wr_q       <= 1'b0;
            oe_q       <= 1'b0;
            a_ack_q    <= 1'b0;
            b_ack_q    <= 1'b0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            cs_q       <= cs_d;
            wr_q       <= wr_d;
            oe_q       <= oe_d;
            a_ack_q    <= a_ack_d;
            b_ack_q    <= b_ack_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
        end
    end

    assign ram_cs   = cs_q;
    assign ram_wr   = wr_q;
    assign ram_oe   = oe_q;
    assign ram_addr = addr_q;

    // Only the registered WR state enables the driver, so the bus is released
    // during IDLE, which doubles as read-to-write turnaround.
    assign ram_data = (state_q == S_WR) ? wdata_q : {DATA_WIDTH{1'bz}};

    assign a_ack    = a_ack_q;
    assign b_ack    = b_ack_q;
    assign a_rvalid = a_rvalid_q;
    assign b_rvalid = b_rvalid_q;
    assign a_rdata  = rdata_q;
    assign b_rdata  = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_arbiter
//  Purpose  : Directed plus random stimulus for ram_arbiter, checked against a
//             transaction-level model with its own RAM behind the data bus.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ram_arbiter;

    localparam int AW = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_ack, a_rvalid, b_ack, b_rvalid;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          ram_cs, ram_wr, ram_oe;
    logic [AW-1:0] ram_addr;
    wire  [DW-1:0] ram_data;

    int total = 0;
    int bad   = 0;

    ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
        .ram_cs(ram_cs), .ram_wr(ram_wr), .ram_oe(ram_oe),
        .ram_addr(ram_addr), .ram_data(ram_data)
    );

    always #5 clk = ~clk;

    // Physical RAM: output updates at negedge, write commits at posedge.
    logic [DW-1:0] ram_mem [16];
    logic [DW-1:0] ram_out;
    always @(negedge clk) if (ram_cs && ram_oe && !ram_wr) ram_out <= ram_mem[ram_addr];
    always @(posedge clk) if (ram_cs && ram_wr) ram_mem[ram_addr] <= ram_data;
    assign ram_data = (ram_cs && ram_oe && !ram_wr) ? ram_out : {DW{1'bz}};

    // Transaction-level reference state
    bit            m_busy, m_own, m_we, m_last;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    logic [DW-1:0] mdl_mem [16];
    bit            e_rva, e_rvb;
    int            a_auto = 0, b_auto = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy  = 0;
        m_own   = 0;
        m_last  = 1;
        m_rdata = '0;
    endtask

    task automatic cycle();
        bit pick_b;
        e_rva = 0;
        e_rvb = 0;
        if (m_busy) begin
            if (!m_we) begin
                m_rdata = mdl_mem[m_addr];
                if (m_own) e_rvb = 1; else e_rva = 1;
            end
            m_busy = 0;
        end else if (a_req || b_req) begin
            pick_b  = b_req && (!a_req || !m_last);
            m_own   = pick_b;
            m_last  = pick_b;
            m_we    = pick_b ? b_we    : a_we;
            m_addr  = pick_b ? b_addr  : a_addr;
            m_wdata = pick_b ? b_wdata : a_wdata;
            if (m_we) mdl_mem[m_addr] = m_wdata;
            m_busy  = 1;
        end
        @(posedge clk);
        #1;
        chk("a_ack",    a_ack,    m_busy && !m_own);
        chk("b_ack",    b_ack,    m_busy && m_own);
        chk("ram_cs",   ram_cs,   m_busy);
        chk("ram_wr",   ram_wr,   m_busy && m_we);
        chk("ram_oe",   ram_oe,   m_busy && !m_we);
        if (m_busy) chk("ram_addr", ram_addr, m_addr);
        if (m_busy && m_we) chk("ram_data", ram_data, m_wdata);
        chk("a_rvalid", a_rvalid, e_rva);
        chk("b_rvalid", b_rvalid, e_rvb);
        chk("a_rdata",  a_rdata,  m_rdata);
        chk("b_rdata",  b_rdata,  m_rdata);
        if (m_busy && !m_own) begin
            a_req = 0;
            if (a_auto > 0) begin a_auto--; a_req = 1; end
        end
        if (m_busy && m_own) begin
            b_req = 0;
            if (b_auto > 0) begin b_auto--; b_req = 1; end
        end
    endtask

    task automatic run_idle(input int max);
        int n = 0;
        while ((a_req || b_req || m_busy) && n < max) begin
            cycle();
            n++;
        end
        chk("drain_timeout", a_req || b_req || m_busy, 0);
    endtask

    task automatic set_a(input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
        a_we = we; a_addr = ad; a_wdata = wd; a_req = 1;
    endtask

    task automatic set_b(input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
        b_we = we; b_addr = ad; b_wdata = wd; b_req = 1;
    endtask

    task automatic do_reset();
        a_req = 0;
        b_req = 0;
        rst   = 1;
        @(posedge clk);
        #1;
        chk("rst_cs",   ram_cs,   0);
        chk("rst_wr",   ram_wr,   0);
        chk("rst_oe",   ram_oe,   0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_ack",  {a_ack, b_ack}, 0);
        chk("rst_rv",   {a_rvalid, b_rvalid}, 0);
        chk("rst_rdata", a_rdata, 0);
        model_reset();
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        rst = 0;
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
        for (int i = 0; i < 16; i++) begin
            ram_mem[i] = '0;
            mdl_mem[i] = '0;
        end
        model_reset();
        #2;
        do_reset();

        // Single write, then read-back by the other requester
        set_a(1, 4'd3, 16'hBEEF);
        run_idle(20);
        set_b(0, 4'd3, 16'h0000);
        run_idle(20);
        chk("readback_b", b_rdata, 16'hBEEF);

        // Simultaneous writes right after reset: A first, then B
        do_reset();
        set_a(1, 4'd1, 16'h1111);
        set_b(1, 4'd2, 16'h2222);
        cycle();
        chk("tie_a_first", a_ack, 1);
        run_idle(20);
        set_a(0, 4'd1, 16'h0000);
        run_idle(20);
        chk("readback_1111", a_rdata, 16'h1111);
        set_b(0, 4'd2, 16'h0000);
        run_idle(20);
        chk("readback_2222", b_rdata, 16'h2222);

        // Continuous contention: 8 reads alternating A,B
        a_auto = 3;
        b_auto = 3;
        set_a(0, 4'd1, 16'h0000);
        set_b(0, 4'd2, 16'h0000);
        run_idle(40);

        // Read immediately followed by write on the same address
        set_a(0, 4'd5, 16'h0000);
        set_b(1, 4'd5, 16'h0F0F);
        run_idle(20);
        set_a(0, 4'd5, 16'h0000);
        run_idle(20);
        chk("readback_0f0f", a_rdata, 16'h0F0F);

        // Reset asserted during the RD cycle
        set_a(0, 4'd3, 16'h0000);
        cycle();
        #2;
        rst = 1;
        #1;
        chk("mid_rst_cs",    ram_cs,   0);
        chk("mid_rst_oe",    ram_oe,   0);
        chk("mid_rst_ack",   a_ack,    0);
        chk("mid_rst_addr",  ram_addr, 0);
        chk("mid_rst_rdata", a_rdata,  0);
        model_reset();
        a_req = 0;
        b_req = 0;
        @(negedge clk);
        rst = 0;
        cycle();
        chk("no_rvalid_after_rst", a_rvalid, 0);
        set_a(1, 4'd7, 16'h7777);
        set_b(1, 4'd8, 16'h8888);
        cycle();
        chk("tie_a_after_rst", a_ack, 1);
        run_idle(20);

        // Random traffic with occasional withdrawal
        for (int n = 0; n < 400; n++) begin
            if (!a_req && $urandom_range(2) == 0)
                set_a(1'($urandom), AW'($urandom), DW'($urandom));
            else if (a_req && $urandom_range(15) == 0)
                a_req = 0;
            if (!b_req && $urandom_range(2) == 0)
                set_b(1'($urandom), AW'($urandom), DW'($urandom));
            else if (b_req && $urandom_range(15) == 0)
                b_req = 0;
            cycle();
        end
        run_idle(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
